// File: rtl/dilithium_pkg.sv
// Shared constants, reader state type and address bit-reversal helper
// for the polynomial RAM masters.
package dilithium_pkg;

  localparam int COEFF_W = 24;
  localparam int ADDR_W  = 8;
  localparam int N       = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    EMIT_LO,
    EMIT_HI
  } state_t;

  // Reverses the ADDR_W-1 pair-index bits.
  function automatic logic [ADDR_W-2:0] brev(input logic [ADDR_W-2:0] v);
    logic [ADDR_W-2:0] r;
    for (int i = 0; i < ADDR_W - 1; i++) begin
      r[i] = v[ADDR_W-2-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/poly_ram_reader.sv
// Unloads one polynomial from a dual-port RAM as a valid/ready coefficient
// stream, reading two words per pair in linear or bit-reversed order.
module poly_ram_reader
  import dilithium_pkg::*;
#(
  parameter int COEFF_W = dilithium_pkg::COEFF_W,
  parameter int ADDR_W  = dilithium_pkg::ADDR_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               bitrev_i,
  output logic [ADDR_W-1:0]  addr1_o,
  output logic [ADDR_W-1:0]  addr2_o,
  output logic               wren_o,
  input  logic [COEFF_W-1:0] data1_i,
  input  logic [COEFF_W-1:0] data2_i,
  output logic [COEFF_W-1:0] coeff_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               last_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(2 ** (ADDR_W - 1));

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  k;
  logic [ADDR_W-1:0]  k_nxt;
  logic [COEFF_W-1:0] lo;
  logic [COEFF_W-1:0] hi;
  logic               mode;
  logic               mode_nxt;
  logic               pair_load;
  logic               done_nxt;
  logic               addr_mode;
  logic [ADDR_W-2:0]  k_low;

  assign wren_o = 1'b0;
  assign busy_o = (state != IDLE);
  assign k_low  = k[ADDR_W-2:0];

  // In IDLE the first pair is fetched with the mode requested alongside start.
  assign addr_mode = (state == IDLE) ? bitrev_i : mode;

  always_comb begin
    if (addr_mode) begin
      addr1_o = {1'b0, brev(k_low)};
      addr2_o = {1'b1, brev(k_low)};
    end else begin
      addr1_o = {k_low, 1'b0};
      addr2_o = {k_low, 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    mode_nxt  = mode;
    pair_load = 1'b0;
    done_nxt  = 1'b0;
    valid_o   = 1'b0;
    coeff_o   = '0;
    last_o    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          pair_load = 1'b1;
          k_nxt     = ADDR_W'(1);
          mode_nxt  = bitrev_i;
          state_nxt = EMIT_LO;
        end
      end
      EMIT_LO: begin
        valid_o = 1'b1;
        coeff_o = lo;
        if (ready_i) begin
          state_nxt = EMIT_HI;
        end
      end
      EMIT_HI: begin
        valid_o = 1'b1;
        coeff_o = hi;
        last_o  = (k == K_LAST);
        // k already addresses the next pair, so it is fetched as hi is accepted.
        if (ready_i) begin
          if (k == K_LAST) begin
            done_nxt  = 1'b1;
            k_nxt     = '0;
            state_nxt = IDLE;
          end else begin
            pair_load = 1'b1;
            k_nxt     = k + ADDR_W'(1);
            state_nxt = EMIT_LO;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      k      <= '0;
      lo     <= '0;
      hi     <= '0;
      mode   <= 1'b0;
      done_o <= 1'b0;
    end else begin
      k      <= k_nxt;
      mode   <= mode_nxt;
      done_o <= done_nxt;
      if (pair_load) begin
        lo <= data1_i;
        hi <= data2_i;
      end
    end
  end

endmodule

// File: tb/tb_poly_ram_reader.sv
// Self-checking bench for poly_ram_reader: a behavioural RAM feeds the
// reader and every accepted coefficient is compared against a reference order.
module tb_poly_ram_reader;

  localparam int AW = 8;
  localparam int CW = 24;
  localparam int N  = 2 ** AW;

  logic          clk;
  logic          rst;
  logic          start;
  logic          bitrev;
  logic [AW-1:0] addr1;
  logic [AW-1:0] addr2;
  logic          wren;
  logic [CW-1:0] data1;
  logic [CW-1:0] data2;
  logic [CW-1:0] coeff;
  logic          valid;
  logic          ready;
  logic          last;
  logic          busy;
  logic          done;

  logic [CW-1:0] ram [N];

  int total = 0;
  int bad   = 0;

  poly_ram_reader #(
    .COEFF_W(CW),
    .ADDR_W (AW)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .bitrev_i(bitrev),
    .addr1_o (addr1),
    .addr2_o (addr2),
    .wren_o  (wren),
    .data1_i (data1),
    .data2_i (data2),
    .coeff_o (coeff),
    .valid_o (valid),
    .ready_i (ready),
    .last_o  (last),
    .busy_o  (busy),
    .done_o  (done)
  );

  assign data1 = ram[addr1];
  assign data2 = ram[addr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full AW-bit reversal of an output position gives its RAM location.
  function automatic int rev(input int j);
    int r = 0;
    for (int b = 0; b < AW; b++) begin
      if (j[b]) r = r | (1 << (AW - 1 - b));
    end
    return r;
  endfunction

  function automatic int loc(input int j, input bit m);
    return m ? rev(j) : j;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_ram(input bit random_data);
    for (int i = 0; i < N; i++) begin
      ram[i] = random_data ? CW'($urandom) : CW'(i);
    end
  endtask

  // Runs one complete unload; poke_idx >= 0 re-pulses start with a flipped
  // bitrev while that coefficient is on the bus.
  task automatic applyStimulus(input bit mode, input int ready_pct, input int poke_idx,
                               input bit full_rate);
    int            idx;
    int            cycles;
    int            nb;
    bit            stalled;
    logic [CW-1:0] held;
    idx     = 0;
    cycles  = 0;
    stalled = 1'b0;
    held    = '0;
    @(negedge clk);
    start  = 1'b1;
    bitrev = mode;
    ready  = 1'b1;
    #1;
    checkOutput("first_addr1", 32'(addr1), 32'(loc(0, mode)));
    checkOutput("first_addr2", 32'(addr2), 32'(loc(1, mode)));
    @(negedge clk);
    start = 1'b0;
    checkOutput("valid_rise", 32'(valid), 32'd1);
    while (idx < N && cycles < 4000) begin
      ready  = (ready_pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < ready_pct);
      start  = (idx == poke_idx);
      bitrev = (idx == poke_idx) ? ~mode : mode;
      checkOutput("valid_held", 32'(valid), 32'd1);
      checkOutput("busy_held", 32'(busy), 32'd1);
      if (stalled) checkOutput("coeff_stable", 32'(coeff), 32'(held));
      nb = (idx | 1) + 1;
      if (nb < N) begin
        checkOutput("next_addr1", 32'(addr1), 32'(loc(nb, mode)));
        checkOutput("next_addr2", 32'(addr2), 32'(loc(nb + 1, mode)));
      end
      if (ready) begin
        checkOutput($sformatf("coeff[%0d]", idx), 32'(coeff), 32'(ram[loc(idx, mode)]));
        checkOutput($sformatf("last[%0d]", idx), 32'(last), 32'(idx == N - 1));
        idx++;
        stalled = 1'b0;
      end else begin
        held    = coeff;
        stalled = 1'b1;
      end
      cycles++;
      @(negedge clk);
    end
    start  = 1'b0;
    bitrev = mode;
    ready  = 1'b0;
    checkOutput("count_in_budget", 32'(idx), 32'(N));
    if (full_rate) checkOutput("cycles", 32'(cycles), 32'(N));
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("valid_after", 32'(valid), 32'd0);
    checkOutput("busy_after", 32'(busy), 32'd0);
    checkOutput("coeff_idle", 32'(coeff), 32'd0);
    @(negedge clk);
    checkOutput("done_single", 32'(done), 32'd0);
    checkOutput("still_idle", 32'(busy), 32'd0);
    checkOutput("idle_addr1", 32'(addr1), 32'd0);
    checkOutput("idle_addr2", 32'(addr2), 32'(loc(1, mode)));
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    bitrev = 1'b0;
    ready  = 1'b0;
    fill_ram(1'b0);
    #3;
    checkOutput("rst_addr1", 32'(addr1), 32'd0);
    checkOutput("rst_addr2", 32'(addr2), 32'd1);
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_wren", 32'(wren), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_valid", 32'(valid), 32'd0);
    checkOutput("idle_coeff", 32'(coeff), 32'd0);
    checkOutput("idle_last", 32'(last), 32'd0);

    applyStimulus(1'b0, 100, -1, 1'b1);
    applyStimulus(1'b1, 100, -1, 1'b1);

    fill_ram(1'b1);
    applyStimulus(1'b0, 50, -1, 1'b0);
    applyStimulus(1'b1, 50, -1, 1'b0);

    fill_ram(1'b0);
    applyStimulus(1'b0, 100, 40, 1'b1);

    // Abort while the upper word of coefficient 101 is stalled.
    @(negedge clk);
    start = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (101) @(negedge clk);
    ready = 1'b0;
    checkOutput("abort_coeff", 32'(coeff), 32'd101);
    checkOutput("abort_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_valid", 32'(valid), 32'd0);
    checkOutput("abort_coeff0", 32'(coeff), 32'd0);
    checkOutput("abort_busy0", 32'(busy), 32'd0);
    checkOutput("abort_addr1", 32'(addr1), 32'd0);
    checkOutput("abort_addr2", 32'(addr2), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("abort_no_done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_no_done_after", 32'(done), 32'd0);
    applyStimulus(1'b0, 100, -1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
